// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED(32,26) Hamming peripheral.
// Holds the codeword geometry, the data-bit to Hamming-position map,
// the data extraction helper and the register-select encodings.
// Optional decoder build switch used by the top: HAMMING_DECODE_EN.
package hamming_pkg;

  localparam int DATA_W = 26;
  localparam int CODE_W = 32;
  localparam int NPAR   = 5;

  // Hamming positions (1-based) holding the parity bits
  localparam logic [4:0] PAR_POS [NPAR] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

  // Register select encodings on reg_sel_i
  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_CODE = 1'b1;

  // Hamming position (1..31) of data bit idx: the idx-th non power-of-two
  function automatic logic [4:0] data_pos(input int idx);
    logic [4:0] pos;
    int         cnt;
    pos = '0;
    cnt = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p[4:0];
        cnt++;
      end
    end
    return pos;
  endfunction

  // Pull the 26 payload bits back out of a codeword
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = c[data_pos(i) - 5'd1];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_secded_enc.sv
// Combinational SECDED(32,26) encoder.
// Code bit k-1 carries Hamming position k (1..31); bit 31 is overall even parity.
module hamming_secded_enc
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CODE_W-1:0] code_o
);

  logic [CODE_W-1:0] code_c;
  logic              par_c;

  // Scatter data into non-parity positions, then fill parity and overall bits
  always_comb begin
    code_c = '0;
    par_c  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      code_c[data_pos(i) - 5'd1] = data_i[i];
    end
    // Parity slots are still zero here, so including them in the XOR is harmless
    for (int j = 0; j < NPAR; j++) begin
      par_c = 1'b0;
      for (int k = 1; k < 32; k++) begin
        if (((k >> j) & 1) == 1) par_c = par_c ^ code_c[k-1];
      end
      code_c[PAR_POS[j] - 5'd1] = par_c;
    end
    code_c[CODE_W-1] = ^code_c[CODE_W-2:0];
  end

  assign code_o = code_c;

endmodule

// File: rtl/perifericos_hamming_top.sv
// Memory-mapped Hamming SECDED(32,26) encoder peripheral.
// sel 0 = DATA (26-bit payload), sel 1 = CODE (32-bit codeword).
// A DATA write arms an encode that lands in CODE on the following edge.
// Build option HAMMING_DECODE_EN adds CODE writes with single-error
// correction / double-error detection and sec/ded status in DATA[31:30].
module perifericos_hamming_top
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic              reg_sel_i,
  input  logic [CODE_W-1:0] entrada_i,
  output logic [CODE_W-1:0] salida_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              enc_pend_q, enc_pend_d;
  logic [CODE_W-1:0] enc_code;

  hamming_secded_enc u_enc (
    .data_i (data_q),
    .code_o (enc_code)
  );

`ifdef HAMMING_DECODE_EN
  logic              dec_pend_q, dec_pend_d;
  logic              sec_q, sec_d;
  logic              ded_q, ded_d;
  logic [DATA_W-1:0] rx_data;
  logic [CODE_W-1:0] rx_chk;
  logic [CODE_W-1:0] dec_code;
  logic [DATA_W-1:0] dec_data;
  logic [4:0]        syn;
  logic              ovr_par;
  logic              dec_sec;
  logic              dec_ded;

  // Re-encode the payload seen in the received word; parity mismatches form the syndrome
  assign rx_data = extract_data(code_q);

  hamming_secded_enc u_chk (
    .data_i (rx_data),
    .code_o (rx_chk)
  );

  // Syndrome / overall-parity classification and single-bit correction
  always_comb begin
    syn      = '0;
    ovr_par  = ^code_q;
    dec_code = code_q;
    dec_sec  = 1'b0;
    dec_ded  = 1'b0;
    for (int j = 0; j < NPAR; j++) begin
      syn[j] = code_q[PAR_POS[j] - 5'd1] ^ rx_chk[PAR_POS[j] - 5'd1];
    end
    if (ovr_par) begin
      dec_sec = 1'b1;
      if (syn != 5'd0) dec_code[syn - 5'd1] = ~dec_code[syn - 5'd1];
      else             dec_code[CODE_W-1]   = ~dec_code[CODE_W-1];
    end else if (syn != 5'd0) begin
      dec_ded = 1'b1;
    end
  end

  assign dec_data = extract_data(dec_code);
`else
  // Upper write-data bits only matter when CODE writes are supported
  logic unused_wr_hi;
  assign unused_wr_hi = ^entrada_i[CODE_W-1:DATA_W];
`endif

  // Next-state: pending operations complete first, a write on the same edge overrides
  always_comb begin
    data_d     = data_q;
    code_d     = code_q;
    enc_pend_d = enc_pend_q;
`ifdef HAMMING_DECODE_EN
    dec_pend_d = dec_pend_q;
    sec_d      = sec_q;
    ded_d      = ded_q;
`endif

    if (enc_pend_q) begin
      code_d     = enc_code;
      enc_pend_d = 1'b0;
    end

`ifdef HAMMING_DECODE_EN
    if (dec_pend_q) begin
      data_d     = dec_data;
      code_d     = dec_code;
      sec_d      = dec_sec;
      ded_d      = dec_ded;
      dec_pend_d = 1'b0;
    end
`endif

    if (wr_i) begin
      if (reg_sel_i == SEL_DATA) begin
        data_d     = entrada_i[DATA_W-1:0];
        enc_pend_d = 1'b1;
`ifdef HAMMING_DECODE_EN
        dec_pend_d = 1'b0;
        sec_d      = 1'b0;
        ded_d      = 1'b0;
`endif
      end else begin
`ifdef HAMMING_DECODE_EN
        code_d     = entrada_i;
        dec_pend_d = 1'b1;
        enc_pend_d = 1'b0;
`endif
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      code_q     <= '0;
      enc_pend_q <= 1'b0;
`ifdef HAMMING_DECODE_EN
      dec_pend_q <= 1'b0;
      sec_q      <= 1'b0;
      ded_q      <= 1'b0;
`endif
    end else begin
      data_q     <= data_d;
      code_q     <= code_d;
      enc_pend_q <= enc_pend_d;
`ifdef HAMMING_DECODE_EN
      dec_pend_q <= dec_pend_d;
      sec_q      <= sec_d;
      ded_q      <= ded_d;
`endif
    end
  end

  // Combinational read mux, no side effects
  always_comb begin
    if (reg_sel_i == SEL_CODE) begin
      salida_o = code_q;
    end else begin
`ifdef HAMMING_DECODE_EN
      salida_o = {sec_q, ded_q, 4'b0000, data_q};
`else
      salida_o = {{(CODE_W-DATA_W){1'b0}}, data_q};
`endif
    end
  end

endmodule

// File: tb/tb_perifericos_hamming_top.sv
// Directed bench for perifericos_hamming_top: vector table plus corner sequences.
module tb_perifericos_hamming_top;

  logic        clk;
  logic        rst;
  logic        wr_i;
  logic        reg_sel_i;
  logic [31:0] entrada_i;
  logic [31:0] salida_o;

  int checks;
  int failures;

  perifericos_hamming_top dut (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (wr_i),
    .reg_sel_i (reg_sel_i),
    .entrada_i (entrada_i),
    .salida_o  (salida_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [31:0] exp_code;
  } vec_t;

  vec_t tbl [8];

  // Reference encoder: parity bits are the XOR of the positions of all set data bits
  function automatic logic [31:0] ref_enc(input logic [25:0] d);
    logic [31:0] c;
    logic [4:0]  x;
    int          idx;
    c   = '0;
    x   = '0;
    idx = 0;
    for (int p = 1; p < 32; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16) begin
        if (d[idx]) begin
          c[p-1] = 1'b1;
          x      = x ^ p[4:0];
        end
        idx++;
      end
    end
    c[0]  = x[0];
    c[1]  = x[1];
    c[3]  = x[2];
    c[7]  = x[3];
    c[15] = x[4];
    c[31] = ^c[30:0];
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Read a register combinationally; called away from the active edge
  task automatic rd(input logic sel, output logic [31:0] val);
    reg_sel_i = sel;
    #1;
    val = salida_o;
  endtask

  // One write cycle; returns at the falling edge just after the write edge
  task automatic do_write(input logic sel, input logic [31:0] val);
    @(negedge clk);
    wr_i      = 1'b1;
    reg_sel_i = sel;
    entrada_i = val;
    @(negedge clk);
    wr_i      = 1'b0;
    entrada_i = '0;
  endtask

  logic [31:0] r;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    wr_i      = 1'b0;
    reg_sel_i = 1'b0;
    entrada_i = '0;

    tbl[0] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0007};
    tbl[1] = '{32'h0000_0002, 32'h0000_0002, 32'h8000_0019};
    tbl[2] = '{32'h0000_0003, 32'h0000_0003, 32'h0000_001E};
    tbl[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[4] = '{32'hFFFF_FFFF, 32'h03FF_FFFF, 32'hFFFF_FFFF};
    tbl[5] = '{32'h0000_0004, 32'h0000_0004, 32'h8000_002A};
    tbl[6] = '{32'hFC00_0007, 32'h0000_0007, 32'h8000_0034};
    tbl[7] = '{32'h0000_0005, 32'h0000_0005, 32'h0000_002D};

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(1'b0, r); check("reset_data", r, 32'h0);
    rd(1'b1, r); check("reset_code", r, 32'h0);

    // Table of single writes, each followed by the encode edge
    for (int i = 0; i < 8; i++) begin
      do_write(1'b0, tbl[i].wdata);
      @(negedge clk);
      rd(1'b0, r); check($sformatf("tbl%0d_data", i), r, tbl[i].exp_data);
      rd(1'b1, r); check($sformatf("tbl%0d_code", i), r, tbl[i].exp_code);
    end

    // Codeword readable only after the encode edge; same-cycle read shows the old one
    do_write(1'b0, 32'h3);
    @(negedge clk);
    do_write(1'b0, 32'h2);
    rd(1'b1, r); check("same_cycle_old_code", r, 32'h0000_001E);
    rd(1'b0, r); check("same_cycle_new_data", r, 32'h0000_0002);
    @(negedge clk);
    rd(1'b1, r); check("after_encode_code", r, 32'h8000_0019);

    // Back-to-back writes each produce their own codeword one edge later
    @(negedge clk);
    wr_i = 1'b1; reg_sel_i = 1'b0; entrada_i = 32'h1;
    @(negedge clk);
    entrada_i = 32'h6;
    @(negedge clk);
    wr_i = 1'b0; entrada_i = '0;
    rd(1'b1, r); check("b2b_first_code", r, 32'h8000_0007);
    @(negedge clk);
    rd(1'b1, r); check("b2b_second_code", r, 32'h0000_0033);
    rd(1'b0, r); check("b2b_second_data", r, 32'h0000_0006);

`ifdef HAMMING_DECODE_EN
    // Single error in position 2 is corrected and flagged
    do_write(1'b1, 32'h8000_0005);
    @(negedge clk);
    rd(1'b0, r); check("dec_sec_data", r, 32'h8000_0001);
    rd(1'b1, r); check("dec_sec_code", r, 32'h8000_0007);
    // Double error is flagged and left uncorrected
    do_write(1'b1, 32'h8000_0004);
    @(negedge clk);
    rd(1'b0, r); check("dec_ded_data", r, 32'h4000_0001);
    rd(1'b1, r); check("dec_ded_code", r, 32'h8000_0004);
    // A DATA write clears the status
    do_write(1'b0, 32'h2);
    rd(1'b0, r); check("dec_clear_status", r, 32'h0000_0002);
    @(negedge clk);
    rd(1'b1, r); check("dec_reencode_code", r, 32'h8000_0019);
`else
    // CODE writes are ignored in the encoder-only build
    do_write(1'b1, 32'h1234_5678);
    @(negedge clk);
    rd(1'b1, r); check("code_write_ignored", r, 32'h0000_0033);
    rd(1'b0, r); check("code_write_data_kept", r, 32'h0000_0006);
`endif

    // Reset while an encode is pending discards it
    do_write(1'b0, 32'h7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(1'b1, r); check("rst_mid_encode_code", r, 32'h0);
    rd(1'b0, r); check("rst_mid_encode_data", r, 32'h0);

    // Sweep small and patterned payloads against the reference encoder
    for (int v = 0; v < 12; v++) begin
      logic [25:0] pl;
      if (v < 8)       pl = 26'(v);
      else if (v == 8) pl = 26'h2AA_AAAA;
      else if (v == 9) pl = 26'h155_5555;
      else if (v == 10) pl = 26'h200_0000;
      else             pl = 26'h0F0_F0F0;
      do_write(1'b0, {6'b0, pl});
      @(negedge clk);
      rd(1'b1, r); check($sformatf("sweep_code_%07h", pl), r, ref_enc(pl));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
